// File: rtl/saturn_bus_controller_pkg.sv
// Shared Saturn nibble-bus definitions: bus command codes, core request op
// encoding, controller FSM states and small decode helpers. Imported by the
// controller and reusable by the ROM/RAM/peripheral responders.
package saturn_bus_controller_pkg;

  localparam int ADDR_W    = 20;
  localparam int ADDR_NIBS = ADDR_W / 4;
  localparam int DATA_W    = 64;

  typedef enum logic [3:0] {
    CMD_PC_READ     = 4'h0,
    CMD_PC_WRITE    = 4'h1,
    CMD_DP_READ     = 4'h2,
    CMD_DP_WRITE    = 4'h3,
    CMD_LOAD_PC     = 4'h4,
    CMD_LOAD_DP     = 4'h5,
    CMD_CONFIGURE   = 4'h6,
    CMD_UNCONFIGURE = 4'h7,
    CMD_RESET       = 4'hF
  } bus_cmd_e;

  // Core ops share their encoding with the transfer commands 0..3.
  typedef enum logic [1:0] {
    OP_PC_READ  = 2'd0,
    OP_PC_WRITE = 2'd1,
    OP_DP_READ  = 2'd2,
    OP_DP_WRITE = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_LOAD,
    ST_ADDR,
    ST_CMD_XFER,
    ST_DATA,
    ST_RSTCMD,
    ST_DONE
  } state_e;

  function automatic logic op_is_write(input req_op_e op);
    return op[0];
  endfunction

  function automatic logic op_uses_dp(input req_op_e op);
    return op[1];
  endfunction

  function automatic bus_cmd_e op_cmd(input req_op_e op);
    return bus_cmd_e'({2'b00, op});
  endfunction

endpackage

// File: rtl/saturn_bus_slot_timer.sv
// Bus slot timer: free-running slot counter, phase output, one-clock slot
// strobe and a sample enable one clock after the strobe (responders register
// their read nibble on the strobe edge).
// Ports:
//   i_clk, i_reset   clock, async active-high reset
//   o_phase          low two bits of the slot counter
//   o_strobe         high for one clock per BUS_DIV clocks
//   o_sample_en      o_strobe delayed by one clock
module saturn_bus_slot_timer #(
  parameter int BUS_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [1:0] o_phase,
  output logic       o_strobe,
  output logic       o_sample_en
);

  localparam int LOG = $clog2(BUS_DIV);
  // Keep at least two bits so o_phase is always fully backed by the counter.
  localparam int CW  = (LOG < 2) ? 2 : LOG;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt         <= '0;
      o_sample_en <= 1'b0;
    end else begin
      cnt         <= cnt + CW'(1);
      o_sample_en <= o_strobe;
    end
  end

  // BUS_DIV is a power of two, so "counter == BUS_DIV-1" is all-ones low bits.
  assign o_strobe = &cnt[LOG-1:0];
  assign o_phase  = cnt[1:0];

endmodule

// File: rtl/saturn_bus_controller.sv
// Saturn nibble-bus initiator. Converts core PC/DP read/write requests of
// 1..16 nibbles into command, address and data slots, and keeps shadow
// copies of the responders' PC/DP pointers to skip redundant LOAD sequences.
// Ports:
//   i_clk, i_reset                 clock, async active-high reset
//   o_phase                        slot phase counter (low bits)
//   i_req_valid/o_req_ready        request handshake
//   i_req_op/addr/len/wdata        request: op, start address, len-1, write nibbles
//   o_rdata, o_done                read nibbles (held), completion pulse
//   i_bus_reset_req                issue the bus RESET command
//   o_bus_clk_en                   slot strobe
//   o_bus_is_data/o_bus_nibble_out registered slot type and nibble
//   i_bus_nibble_in                responder nibble
module saturn_bus_controller
  import saturn_bus_controller_pkg::*;
#(
  parameter int BUS_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [1:0]        o_phase,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [3:0]        i_req_len,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done,
  input  logic              i_bus_reset_req,
  output logic              o_bus_clk_en,
  output logic              o_bus_is_data,
  output logic [3:0]        o_bus_nibble_out,
  input  logic [3:0]        i_bus_nibble_in
);

  state_e              state;
  req_op_e             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          idx;
  logic [ADDR_W-1:0]   pc_shadow, dp_shadow;
  logic                pc_shadow_v, dp_shadow_v;
  req_op_e             last_cmd;
  logic                last_cmd_v;
  logic                rd_pending;
  logic [3:0]          rd_idx;
  logic                sample_en;
  req_op_e             req_op;
  logic                shadow_hit, cmd_hit;

  saturn_bus_slot_timer #(.BUS_DIV(BUS_DIV)) u_slot_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .o_phase     (o_phase),
    .o_strobe    (o_bus_clk_en),
    .o_sample_en (sample_en)
  );

  assign req_op = req_op_e'(i_req_op);

  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    if (op_uses_dp(req_op)) shadow_hit = dp_shadow_v && (dp_shadow == i_req_addr);
    else                    shadow_hit = pc_shadow_v && (pc_shadow == i_req_addr);
    cmd_hit = last_cmd_v && (last_cmd == req_op);
  end

  // Nibble driven in data slot i: write data, or 0 while reading.
  function automatic logic [3:0] data_nib(input req_op_e op, input logic [DATA_W-1:0] wd,
                                          input logic [3:0] i);
    return op_is_write(op) ? wd[{i, 2'b00} +: 4] : 4'h0;
  endfunction

  // Slot outputs are loaded when a slot begins (on accept or on the strobe
  // ending the previous slot), so they are stable at the strobe that consumes it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= ST_IDLE;
      op_q             <= OP_PC_READ;
      addr_q           <= '0;
      len_q            <= '0;
      wdata_q          <= '0;
      idx              <= '0;
      pc_shadow        <= '0;
      dp_shadow        <= '0;
      pc_shadow_v      <= 1'b0;
      dp_shadow_v      <= 1'b0;
      last_cmd         <= OP_PC_READ;
      last_cmd_v       <= 1'b0;
      rd_pending       <= 1'b0;
      rd_idx           <= '0;
      o_req_ready      <= 1'b1;
      o_rdata          <= '0;
      o_done           <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
    end else begin
      o_done <= 1'b0;

      // The responder updates its nibble on the strobe edge; take it one clock later.
      if (sample_en && rd_pending) begin
        o_rdata[{rd_idx, 2'b00} +: 4] <= i_bus_nibble_in;
        rd_pending                    <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!o_req_ready) begin
            o_req_ready <= 1'b1;
          end else if (i_bus_reset_req) begin
            o_req_ready      <= 1'b0;
            state            <= ST_RSTCMD;
            o_bus_is_data    <= 1'b0;
            o_bus_nibble_out <= CMD_RESET;
          end else if (i_req_valid) begin
            o_req_ready <= 1'b0;
            op_q        <= req_op;
            addr_q      <= i_req_addr;
            len_q       <= i_req_len;
            wdata_q     <= i_req_wdata;
            o_rdata     <= '0;
            idx         <= '0;
            if (shadow_hit && cmd_hit) begin
              state            <= ST_DATA;
              o_bus_is_data    <= 1'b1;
              o_bus_nibble_out <= data_nib(req_op, i_req_wdata, 4'd0);
            end else if (shadow_hit) begin
              state            <= ST_CMD_XFER;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= op_cmd(req_op);
            end else begin
              state            <= ST_CMD_LOAD;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= op_uses_dp(req_op) ? CMD_LOAD_DP : CMD_LOAD_PC;
            end
          end
        end

        ST_CMD_LOAD: if (o_bus_clk_en) begin
          state            <= ST_ADDR;
          idx              <= '0;
          o_bus_is_data    <= 1'b1;
          o_bus_nibble_out <= addr_q[3:0];
        end

        ST_ADDR: if (o_bus_clk_en) begin
          if (idx == 4'(ADDR_NIBS - 1)) begin
            if (op_is_write(op_q)) begin
              state            <= ST_CMD_XFER;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= op_cmd(op_q);
            end else begin
              // Responders switch to read after the address; no transfer command.
              last_cmd         <= op_q;
              last_cmd_v       <= 1'b1;
              state            <= ST_DATA;
              idx              <= '0;
              o_bus_nibble_out <= 4'h0;
            end
          end else begin
            idx              <= idx + 4'd1;
            o_bus_nibble_out <= addr_q[{idx[2:0] + 3'd1, 2'b00} +: 4];
          end
        end

        ST_CMD_XFER: if (o_bus_clk_en) begin
          last_cmd         <= op_q;
          last_cmd_v       <= 1'b1;
          state            <= ST_DATA;
          idx              <= '0;
          o_bus_is_data    <= 1'b1;
          o_bus_nibble_out <= data_nib(op_q, wdata_q, 4'd0);
        end

        ST_DATA: if (o_bus_clk_en) begin
          if (!op_is_write(op_q)) begin
            rd_pending <= 1'b1;
            rd_idx     <= idx;
          end
          if (idx == len_q) begin
            state <= ST_DONE;
          end else begin
            idx              <= idx + 4'd1;
            o_bus_nibble_out <= data_nib(op_q, wdata_q, idx + 4'd1);
          end
        end

        ST_DONE: begin
          // Responder pointer now sits one past the last nibble, wrapping at 2^20.
          if (op_uses_dp(op_q)) begin
            dp_shadow   <= addr_q + ADDR_W'(len_q) + ADDR_W'(1);
            dp_shadow_v <= 1'b1;
          end else begin
            pc_shadow   <= addr_q + ADDR_W'(len_q) + ADDR_W'(1);
            pc_shadow_v <= 1'b1;
          end
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end

        ST_RSTCMD: if (o_bus_clk_en) begin
          pc_shadow_v <= 1'b0;
          dp_shadow_v <= 1'b0;
          last_cmd_v  <= 1'b0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_bus_controller.sv
// Self-checking bench for saturn_bus_controller: expected bus slots are
// queued when a request is driven and popped at every slot strobe; a small
// ROM model supplies read nibbles and the expected o_rdata.
module tb_saturn_bus_controller;

  localparam int BUS_DIV = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  o_phase;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [1:0]  i_req_op = '0;
  logic [19:0] i_req_addr = '0;
  logic [3:0]  i_req_len = '0;
  logic [63:0] i_req_wdata = '0;
  logic [63:0] o_rdata;
  logic        o_done;
  logic        i_bus_reset_req = 1'b0;
  logic        o_bus_clk_en;
  logic        o_bus_is_data;
  logic [3:0]  o_bus_nibble_out;
  logic [3:0]  i_bus_nibble_in = '0;

  saturn_bus_controller #(.BUS_DIV(BUS_DIV)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .o_phase          (o_phase),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_op         (i_req_op),
    .i_req_addr       (i_req_addr),
    .i_req_len        (i_req_len),
    .i_req_wdata      (i_req_wdata),
    .o_rdata          (o_rdata),
    .o_done           (o_done),
    .i_bus_reset_req  (i_bus_reset_req),
    .o_bus_clk_en     (o_bus_clk_en),
    .o_bus_is_data    (o_bus_is_data),
    .o_bus_nibble_out (o_bus_nibble_out),
    .i_bus_nibble_in  (i_bus_nibble_in)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       is_data;
    logic [3:0] nib;
    logic       rd;
    logic [3:0] rd_nib;
  } slot_t;

  typedef enum int { P_FULL, P_XFER, P_DIRECT } path_e;

  slot_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rom_nib(input logic [19:0] a);
    return a[3:0] ^ a[7:4] ^ a[19:16] ^ 4'h9;
  endfunction

  task automatic push_slot(input logic d, input logic [3:0] n, input logic r, input logic [3:0] rn);
    slot_t s;
    s.is_data = d;
    s.nib     = n;
    s.rd      = r;
    s.rd_nib  = rn;
    exp_q.push_back(s);
  endtask

  // Queue the slots a request must produce and return its expected o_rdata.
  task automatic expect_req(input logic [1:0] op, input logic [19:0] addr, input logic [3:0] len,
                            input logic [63:0] wdata, input path_e path, output logic [63:0] er);
    logic [3:0] rn;
    er = '0;
    if (path == P_FULL) begin
      push_slot(1'b0, op[1] ? 4'h5 : 4'h4, 1'b0, 4'h0);
      for (int k = 0; k < 5; k++) push_slot(1'b1, addr[4*k +: 4], 1'b0, 4'h0);
      if (op[0]) push_slot(1'b0, {2'b00, op}, 1'b0, 4'h0);
    end else if (path == P_XFER) begin
      push_slot(1'b0, {2'b00, op}, 1'b0, 4'h0);
    end
    for (int i = 0; i <= int'(len); i++) begin
      if (op[0]) begin
        push_slot(1'b1, wdata[4*i +: 4], 1'b0, 4'h0);
      end else begin
        rn = rom_nib(addr + 20'(i));
        push_slot(1'b1, 4'h0, 1'b1, rn);
        er[4*i +: 4] = rn;
      end
    end
  endtask

  // Called at a negedge; leaves the bench one clock after the accepting edge.
  task automatic do_req(input logic [1:0] op, input logic [19:0] addr, input logic [3:0] len,
                        input logic [63:0] wdata, input logic rst_req);
    int w = 0;
    while (!o_req_ready && w < 64) begin
      @(negedge i_clk);
      w++;
    end
    check("ready_before_req", 64'(o_req_ready), 64'd1);
    i_req_op        = op;
    i_req_addr      = addr;
    i_req_len       = len;
    i_req_wdata     = wdata;
    i_req_valid     = 1'b1;
    i_bus_reset_req = rst_req;
    @(posedge i_clk);
    #1;
    i_req_valid     = 1'b0;
    i_bus_reset_req = 1'b0;
  endtask

  // Compare one strobed slot; for read slots act as the responder, which
  // changes its nibble just after the strobe edge.
  task automatic handle_strobe();
    slot_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("slot", 64'({o_bus_is_data, o_bus_nibble_out}), 64'({s.is_data, s.nib}));
      if (s.rd) begin
        i_bus_nibble_in = ~s.rd_nib;
        @(posedge i_clk);
        #1;
        i_bus_nibble_in = s.rd_nib;
      end
    end
  endtask

  task automatic run_bus(input int max_cyc, input logic want_done, input logic [63:0] er,
                         output int cyc_done);
    int done_cnt = 0;
    cyc_done = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        done_cnt++;
        if (cyc_done < 0) cyc_done = c;
      end
      if (o_bus_clk_en) handle_strobe();
      if (want_done && done_cnt > 0) break;
    end
    check("done_count", 64'(done_cnt), 64'(want_done));
    check("slots_left", 64'(exp_q.size()), 64'd0);
    if (want_done) begin
      check("rdata", o_rdata, er);
      check("ready_during_done", 64'(o_req_ready), 64'd0);
      @(negedge i_clk);
      check("done_width", 64'(o_done), 64'd0);
      check("ready_after_done", 64'(o_req_ready), 64'd1);
    end else begin
      check("ready_idle", 64'(o_req_ready), 64'd1);
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [19:0] addr, input logic [3:0] len,
                     input logic [63:0] wdata, input path_e path, output int cyc);
    logic [63:0] er;
    expect_req(op, addr, len, wdata, path, er);
    do_req(op, addr, len, wdata, 1'b0);
    run_bus(400, 1'b1, er, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          strobes;
    logic [63:0] er;

    repeat (3) @(posedge i_clk);
    #1;
    check("reset_ready", 64'(o_req_ready), 64'd1);
    check("reset_bus", 64'({o_phase, o_done, o_bus_clk_en, o_bus_is_data, o_bus_nibble_out}), 64'd0);
    check("reset_rdata", o_rdata, 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // Cold PC read: LOAD_PC, address 00000, five reads.
    txn(2'd0, 20'h00000, 4'd4, 64'd0, P_FULL, cyc);
    // Pointer and last command already match: data only, within one slot.
    txn(2'd0, 20'h00005, 4'd0, 64'd0, P_DIRECT, cyc);
    check("direct_latency", 64'(cyc >= 3 && cyc <= BUS_DIV + 2), 64'd1);
    // DP write: LOAD_DP, address, DP_WRITE command, data C,B,A.
    txn(2'd3, 20'h12345, 4'd2, 64'hABC, P_FULL, cyc);
    // DP read across the top of the address space.
    txn(2'd2, 20'hFFFFE, 4'd3, 64'd0, P_FULL, cyc);
    // Wrapped DP pointer is 00002 and last command is DP_READ.
    txn(2'd2, 20'h00002, 4'd1, 64'd0, P_DIRECT, cyc);
    // PC pointer matches (00006) but last command differs: transfer command only.
    txn(2'd1, 20'h00006, 4'd1, 64'h5E, P_XFER, cyc);

    // Bus reset request wins over a simultaneous request; no o_done.
    push_slot(1'b0, 4'hF, 1'b0, 4'h0);
    do_req(2'd0, 20'h00008, 4'd1, 64'd0, 1'b1);
    run_bus(6 * BUS_DIV, 1'b0, 64'd0, cyc);
    // PC pointer would match 00008, but shadows were invalidated.
    txn(2'd0, 20'h00008, 4'd1, 64'd0, P_FULL, cyc);

    // Reset during the third address slot.
    expect_req(2'd2, 20'h0ABCD, 4'd2, 64'd0, P_FULL, er);
    do_req(2'd2, 20'h0ABCD, 4'd2, 64'd0, 1'b0);
    strobes = 0;
    for (int c = 0; c < 100 && strobes < 3; c++) begin
      @(negedge i_clk);
      if (o_bus_clk_en) begin
        handle_strobe();
        strobes++;
      end
    end
    check("abort_reached", 64'(strobes), 64'd3);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("abort_bus", 64'({o_phase, o_done, o_bus_clk_en, o_bus_is_data, o_bus_nibble_out}), 64'd0);
    check("abort_ready", 64'(o_req_ready), 64'd1);
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.delete();
    run_bus(8 * BUS_DIV, 1'b0, 64'd0, cyc);
    // PC shadow (0000A) was valid before the reset; a full LOAD proves it was cleared.
    txn(2'd0, 20'h0000A, 4'd0, 64'd0, P_FULL, cyc);
    // Maximum length read, 16 nibbles fill all of o_rdata.
    txn(2'd0, 20'h0000B, 4'd15, 64'd0, P_DIRECT, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
